// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and defaults for the word-addressed data-memory responder.
//   state_t : responder FSM states (IDLE, WAIT, RESP)
//   op_t    : latched operation kind (OP_READ, OP_WRITE)
//   DMEM_ADDR_W / DMEM_DATA_W : default word-address and data widths
//   DMEM_CNT_W : wait-state counter width (covers WAIT_CYCLES up to 15)
//   wait_load() : counter preload for a given wait-state count

package dmem_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // The counter spends one cycle per count including zero, so it is preloaded
  // with one less than the number of wait states. Zero wait states never
  // enter WAIT, so the preload value is irrelevant in that case.
  function automatic logic [DMEM_CNT_W-1:0] wait_load(input int unsigned cycles);
    if (cycles > 0)
      return DMEM_CNT_W'(cycles - 1);
    else
      return '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Word-organised storage with a synchronous byte-enabled write port and an
// asynchronous read port. Contents are not affected by any reset.
//   clk     : write clock
//   wr_en   : write strobe, sampled on the rising edge
//   wr_addr : write word address
//   wr_data : write data
//   wr_be   : per-byte write enable (bit b covers wr_data[8b+7:8b])
//   rd_addr : read word address
//   rd_data : combinational read data

module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Single-initiator data-memory responder with a fixed number of wait states.
// A request (READ xor WRITE) seen in IDLE is latched, held for WAIT_CYCLES
// cycles, then completed with a one-cycle READY pulse in RESP. READ and WRITE
// together in IDLE are rejected with a one-cycle ERROR pulse.
//   CLK      : clock, all state changes on the rising edge
//   RESET    : synchronous active-high reset (storage is kept)
//   READ     : read request
//   WRITE    : write request
//   ADDRESS  : word address
//   DATA_IN  : write data
//   BYTE_EN  : per-byte write enable, ignored for reads
//   DATA_OUT : read data, held until the next read completes
//   READY    : completion pulse, high only during RESP
//   ERROR    : protocol-error pulse
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; request inputs are only looked at here
// WAIT  | wait states; counter runs down to zero, then go to RESP
// RESP  | READY high, read data valid; write commits at the end edge

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W      = DMEM_ADDR_W,
  parameter int          DATA_W      = DMEM_DATA_W,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                READ,
  input  logic                WRITE,
  input  logic [ADDR_W-1:0]   ADDRESS,
  input  logic [DATA_W-1:0]   DATA_IN,
  input  logic [DATA_W/8-1:0] BYTE_EN,
  output logic [DATA_W-1:0]   DATA_OUT,
  output logic                READY,
  output logic                ERROR
);

  localparam int                    BE_W     = DATA_W / 8;
  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  state_t                state;
  op_t                   op_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [BE_W-1:0]       be_q;
  logic [DMEM_CNT_W-1:0] cnt;

  logic                  mem_we;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;

  // With zero wait states the read data is captured on the sampling edge,
  // before addr_q holds the request address, so IDLE reads from the live
  // ADDRESS bus instead.
  assign rd_addr = (state == IDLE) ? ADDRESS : addr_q;

  // The write lands on the edge that closes RESP; a reset on that same edge
  // aborts it.
  assign mem_we = (state == RESP) && (op_q == OP_WRITE) && !RESET;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (CLK),
    .wr_en   (mem_we),
    .wr_addr (addr_q),
    .wr_data (data_q),
    .wr_be   (be_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      READY    <= 1'b0;
      ERROR    <= 1'b0;
      DATA_OUT <= '0;
      op_q     <= OP_READ;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
    end else begin
      READY <= 1'b0;
      ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (READ && WRITE) begin
            ERROR <= 1'b1;
          end else if (READ || WRITE) begin
            op_q   <= WRITE ? OP_WRITE : OP_READ;
            addr_q <= ADDRESS;
            data_q <= DATA_IN;
            be_q   <= BYTE_EN;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
              READY <= 1'b1;
              if (READ) DATA_OUT <= rd_data;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            READY <= 1'b1;
            if (op_q == OP_READ) DATA_OUT <= rd_data;
          end else begin
            cnt <= cnt - DMEM_CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed bench for dmem_responder: one instance with two wait states and
// one with zero wait states, each checked against hand-computed values.

module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WAIT_CYCLES = 2 instance
  logic        rst2, rd2, wr2;
  logic [9:0]  addr2;
  logic [31:0] din2;
  logic [3:0]  be2;
  logic [31:0] dout2;
  logic        ready2, err2;

  // WAIT_CYCLES = 0 instance
  logic        rst0, rd0, wr0;
  logic [9:0]  addr0;
  logic [31:0] din0;
  logic [3:0]  be0;
  logic [31:0] dout0;
  logic        ready0, err0;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(2)) dut2 (
    .CLK(clk), .RESET(rst2), .READ(rd2), .WRITE(wr2), .ADDRESS(addr2),
    .DATA_IN(din2), .BYTE_EN(be2), .DATA_OUT(dout2), .READY(ready2), .ERROR(err2)
  );

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RESET(rst0), .READ(rd0), .WRITE(wr0), .ADDRESS(addr0),
    .DATA_IN(din0), .BYTE_EN(be0), .DATA_OUT(dout0), .READY(ready0), .ERROR(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on dut2, held for the sampling edge only. During the following
  // cycle the request inputs are scrambled so that anything not latched would
  // show up. Observes 6 cycles after the sampling edge.
  task automatic txn2(input logic rd, input logic wr, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output int lat, output int n_rdy, output int n_err,
                      output logic [31:0] q);
    rd2 = rd; wr2 = wr; addr2 = a; din2 = d; be2 = be;
    tick();
    rd2 = 1'b0; wr2 = 1'b0; addr2 = a ^ 10'h003; din2 = ~d; be2 = ~be;
    lat = 0; n_rdy = 0; n_err = 0; q = '0;
    for (int k = 1; k <= 6; k++) begin
      if (ready2) begin
        n_rdy++;
        if (lat == 0) begin
          lat = k;
          q   = dout2;
        end
      end
      if (err2) n_err++;
      tick();
    end
  endtask

  task automatic wr0_word(input logic [9:0] a, input logic [31:0] d);
    wr0 = 1'b1; rd0 = 1'b0; addr0 = a; din0 = d; be0 = 4'hF;
    tick();
    wr0 = 1'b0;
    chk("wc0_prewrite_ready", {31'd0, ready0}, 32'd1);
    tick();
  endtask

  int          lat, nr, ne;
  logic [31:0] q;

  initial begin
    rst2 = 1'b1; rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; din2 = '0; be2 = '0;
    rst0 = 1'b1; rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0; be0 = '0;
    tick();
    tick();
    rst2 = 1'b0; rst0 = 1'b0;
    tick();

    chk("rst_ready", {31'd0, ready2}, 32'd0);
    chk("rst_error", {31'd0, err2}, 32'd0);
    chk("rst_dout", dout2, 32'd0);
    chk("rst0_dout", dout0, 32'd0);

    // full write then read back, latency 3
    txn2(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, lat, nr, ne, q);
    chk("wr_full_latency", lat, 3);
    chk("wr_full_nready", nr, 1);
    chk("wr_dout_untouched", dout2, 32'd0);
    txn2(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, lat, nr, ne, q);
    chk("rd_full_latency", lat, 3);
    chk("rd_full_data", q, 32'hDEADBEEF);
    chk("rd_full_hold", dout2, 32'hDEADBEEF);

    // partial byte write
    txn2(1'b0, 1'b1, 10'h005, 32'h11223344, 4'b0101, lat, nr, ne, q);
    chk("wr_part_latency", lat, 3);
    chk("wr_part_dout_hold", dout2, 32'hDEADBEEF);
    txn2(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, lat, nr, ne, q);
    chk("rd_part_data", q, 32'hDE22BE44);

    // READ and WRITE together: error only, no access
    txn2(1'b0, 1'b1, 10'h010, 32'hA5A5A5A5, 4'hF, lat, nr, ne, q);
    txn2(1'b1, 1'b1, 10'h010, 32'hFFFFFFFF, 4'hF, lat, nr, ne, q);
    chk("err_pulses", ne, 1);
    chk("err_no_ready", nr, 0);
    chk("err_dout_hold", dout2, 32'hDE22BE44);
    txn2(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, lat, nr, ne, q);
    chk("err_mem_kept", q, 32'hA5A5A5A5);
    chk("err_rd_noerr", ne, 0);

    // reset during WAIT aborts a write
    txn2(1'b0, 1'b1, 10'h3FF, 32'h0BADF00D, 4'hF, lat, nr, ne, q);
    wr2 = 1'b1; addr2 = 10'h3FF; din2 = 32'hCAFEF00D; be2 = 4'hF;
    tick();
    wr2 = 1'b0;
    chk("abort_in_wait_ready", {31'd0, ready2}, 32'd0);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    chk("abort_ready", {31'd0, ready2}, 32'd0);
    chk("abort_error", {31'd0, err2}, 32'd0);
    chk("abort_dout", dout2, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_late_ready", {31'd0, ready2}, 32'd0);
      tick();
    end
    txn2(1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0, lat, nr, ne, q);
    chk("abort_mem_old", q, 32'h0BADF00D);
    txn2(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, lat, nr, ne, q);
    chk("reset_keeps_mem", q, 32'hDE22BE44);

    // inputs changed during WAIT must not matter (scramble hits addr 0x002)
    txn2(1'b0, 1'b1, 10'h002, 32'h22222222, 4'hF, lat, nr, ne, q);
    txn2(1'b0, 1'b1, 10'h001, 32'h12345678, 4'hF, lat, nr, ne, q);
    txn2(1'b1, 1'b0, 10'h001, 32'h0, 4'h0, lat, nr, ne, q);
    chk("latched_data", q, 32'h12345678);
    txn2(1'b1, 1'b0, 10'h002, 32'h0, 4'h0, lat, nr, ne, q);
    chk("latched_addr_neighbour", q, 32'h22222222);

    // zero wait states: back-to-back reads with READ held high
    wr0_word(10'h000, 32'h0000AAAA);
    wr0_word(10'h001, 32'h0001BBBB);
    rd0 = 1'b1; addr0 = 10'h000;
    tick();
    chk("b2b_ready_1", {31'd0, ready0}, 32'd1);
    chk("b2b_data_1", dout0, 32'h0000AAAA);
    addr0 = 10'h001;
    tick();
    chk("b2b_gap", {31'd0, ready0}, 32'd0);
    chk("b2b_gap_hold", dout0, 32'h0000AAAA);
    tick();
    chk("b2b_ready_2", {31'd0, ready0}, 32'd1);
    chk("b2b_data_2", dout0, 32'h0001BBBB);
    rd0 = 1'b0;
    tick();
    chk("b2b_end", {31'd0, ready0}, 32'd0);

    // zero wait states: read issued right after a write to the same word
    wr0 = 1'b1; addr0 = 10'h007; din0 = 32'h77777777; be0 = 4'hF;
    tick();
    chk("raw_wr_ready", {31'd0, ready0}, 32'd1);
    wr0 = 1'b0; rd0 = 1'b1;
    tick();
    chk("raw_idle", {31'd0, ready0}, 32'd0);
    tick();
    rd0 = 1'b0;
    chk("raw_rd_ready", {31'd0, ready0}, 32'd1);
    chk("raw_rd_data", dout0, 32'h77777777);
    chk("raw_no_error", {31'd0, err0}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width (depth 2**ADDR_W words).
REQ-002 Parameter DATA_W, default 32, data word width; multiple of 8.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states inserted per access; legal range 0..15.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 READ  input  1  read request from the core-side initiator.
REQ-007 WRITE  input  1  write request from the core-side initiator.
REQ-008 ADDRESS  input  ADDR_W  word address of the request.
REQ-009 DATA_IN  input  DATA_W  write data from the initiator.
REQ-010 BYTE_EN  input  DATA_W/8  per-byte write enable; ignored for reads.
REQ-011 DATA_OUT  output  DATA_W  read data returned to the initiator.
REQ-012 READY  output  1  one-cycle completion pulse.
REQ-013 ERROR  output  1  one-cycle protocol-error pulse.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 In IDLE, READ xor WRITE sampled high SHALL latch ADDRESS, DATA_IN, BYTE_EN and the operation; next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-016 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; WAIT exits to RESP when the count is 0.
REQ-017 READY SHALL be high only in RESP, exactly WAIT_CYCLES+1 cycles after the sampling edge; RESP always returns to IDLE after one cycle.
REQ-018 Request inputs SHALL be ignored outside IDLE; only latched values are used.
REQ-019 A write SHALL update only the bytes with BYTE_EN=1, at the edge that ends the RESP cycle.
REQ-020 A read SHALL drive the addressed word on DATA_OUT during the RESP cycle; DATA_OUT holds that value until the next read completes.
REQ-021 Writes SHALL NOT alter DATA_OUT.
REQ-022 A read issued immediately after a write to the same address SHALL return the written data.
REQ-023 READ and WRITE both high in IDLE SHALL produce ERROR=1 in the next cycle, with no access and no READY, then return to IDLE.
REQ-024 A request still held high in the cycle after RESP SHALL be sampled as a new, back-to-back transaction.
REQ-025 The address space SHALL be exhaustive: every ADDRESS value is valid, with no wrap or aliasing logic.

Reset
REQ-026 RESET SHALL force state=IDLE, counter=0, READY=0, ERROR=0 and DATA_OUT=0 on the next edge.
REQ-027 RESET asserted during WAIT or RESP SHALL abort the transaction; a pending write SHALL NOT modify storage.
REQ-028 Storage contents SHALL NOT be cleared by RESET.

Structure
REQ-029 Package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the op enum (OP_READ/OP_WRITE) and the default ADDR_W/DATA_W constants.
REQ-030 Storage SHALL be a sub-module, dmem_array, with a synchronous byte-enabled write and an asynchronous read.
REQ-031 The FSM, counter and request latches SHALL reside in dmem_responder.

Verification
REQ-032 WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x005 with BYTE_EN=4'hF -> READY high exactly 3 cycles after sampling; a following read of 0x005 returns 0xDEADBEEF.
REQ-033 Starting from 0xDEADBEEF, write 0x11223344 to addr 0x005 with BYTE_EN=4'b0101 -> a following read returns 0xDE22BE44.
REQ-034 READ=WRITE=1 in IDLE at addr 0x010 -> ERROR pulses once, READY stays 0, and addr 0x010 contents are unchanged.
REQ-035 RESET asserted in the WAIT cycle of a write of 0xCAFEF00D to addr 0x3FF -> outputs return to 0 the next cycle; a later read of 0x3FF returns the old value.
REQ-036 WAIT_CYCLES=0 with READ held high across back-to-back reads of 0x000 then 0x001 -> READY pulses every 2 cycles and DATA_OUT returns each word in order.
REQ-037 Write 0x12345678 to addr 0x001, then change ADDRESS and DATA_IN during WAIT -> the stored data and address are those latched at sampling.
